// File: rtl/mac_pkg.sv
// Shared constants and helpers for the multiply-accumulate datapath.
// Latency: none (package only).
// Backpressure: none (package only).
package mac_pkg;

    // Register stages inside the 4x4 unsigned multiplier feeding the accumulator.
    localparam int MULT_LATENCY = 3;

    // Width of one multiplier product.
    localparam int PROD_W = 8;

    typedef logic [PROD_W-1:0] prod_t;

    // Bits needed for a counter that runs 0..count-1; never narrower than 1.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that carries a valid flag alongside a stall-free pipeline.
// Latency: DEPTH cycles from d_vld to q_vld.
// Backpressure: none; it shifts every cycle, matching a pipeline that cannot stall.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears every tap
//   d_vld - flag entering the pipeline this cycle
//   q_vld - flag leaving the pipeline, DEPTH cycles later
module valid_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_vld,
    output logic q_vld
);

    logic [DEPTH-1:0] taps;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    taps <= '0;
                end else begin
                    taps <= d_vld;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    taps <= '0;
                end else begin
                    taps <= {taps[DEPTH-2:0], d_vld};
                end
            end
        end
    endgenerate

    assign q_vld = taps[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// Sums each group of COUNT multiplier products into one dot-product result.
// Latency: last operand issue to out_valid is LATENCY+1 cycles; one product per cycle.
// Backpressure: only the last issue of a group is held off while an earlier result is unaccepted.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset; discards any partial group
//   in_valid  - operands presented to the multiplier this cycle
//   in_ready  - issue permitted (combinational from issue_cnt, out_valid, out_ready)
//   z         - multiplier product, meaningful when the delay line says so
//   out_data  - completed group sum
//   out_valid - out_data holds an unaccepted result
//   out_ready - downstream accepts out_data
//   out_ovf   - group sum exceeded the ACC_W range (qualified by out_valid)
//
// Build option: PRODUCT_ACC_SATURATE_EN clamps an overflowing result to all-ones
// instead of wrapping it modulo 2^ACC_W.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int LATENCY = MULT_LATENCY,
    parameter int PROD_W  = mac_pkg::PROD_W,
    parameter int ACC_W   = 10,
    parameter int COUNT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] z,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ovf
);

    localparam int               CNT_W   = cnt_width(COUNT);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(COUNT - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;
    logic             issue;
    logic             prod_vld;
    logic [ACC_W:0]   sum;
    logic             grp_ovf;
    logic             grp_last;
    logic [ACC_W-1:0] result;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    // The multiplier cannot stall, so the only safe point to hold back is the
    // final operand of a group. Because COUNT exceeds LATENCY, the previous
    // group's result has already landed in the output register by the time
    // this operand is offered, so checking out_valid here is sufficient.
    assign in_ready = !((issue_cnt == LAST) && out_valid && !out_ready);
    assign issue    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (issue) begin
            issue_cnt <= (issue_cnt == LAST) ? '0 : issue_cnt + 1'b1;
        end
    end

    // Marks the cycle in which z carries the product of an accepted issue.
    // Clearing it on reset makes any products still in flight invisible.
    valid_delay_line #(
        .DEPTH (LATENCY)
    ) u_vld_dly (
        .clk   (clk),
        .rst   (rst),
        .d_vld (issue),
        .q_vld (prod_vld)
    );

    // ------------------------------------------------------------------
    // Accumulate side
    // ------------------------------------------------------------------
    // One guard bit catches the carry of this addition; acc_ovf remembers
    // any earlier carry so overflow is sticky across the whole group.
    assign sum      = {1'b0, acc} + (ACC_W + 1)'(z);
    assign grp_ovf  = acc_ovf | sum[ACC_W];
    assign grp_last = (rx_cnt == LAST);

`ifdef PRODUCT_ACC_SATURATE_EN
    assign result = grp_ovf ? ACC_MAX : sum[ACC_W-1:0];
`else
    assign result = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            acc_ovf   <= 1'b0;
            rx_cnt    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            if (prod_vld) begin
                if (grp_last) begin
                    acc      <= '0;
                    acc_ovf  <= 1'b0;
                    rx_cnt   <= '0;
                    out_data <= result;
                    out_ovf  <= grp_ovf;
                end else begin
                    acc      <= sum[ACC_W-1:0];
                    acc_ovf  <= grp_ovf;
                    rx_cnt   <= rx_cnt + 1'b1;
                end
            end

            // A completion landing in the same cycle as a transfer keeps
            // out_valid high so the new result follows without a bubble.
            if (prod_vld && grp_last) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator with a behavioural 3-stage multiplier.
// Latency: drives operands and expects group results LATENCY+1 cycles after the last issue.
// Backpressure: exercises out_ready stalls and the last-issue hold-off on in_ready.
module tb_product_accumulator;
    import mac_pkg::*;

    localparam int ACC_W  = 10;
    localparam int COUNT  = 4;
    localparam int N_RAND = 1000;

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam int EXP9 = 511;
`else
    localparam int EXP9 = 388;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [3:0]       x;
    logic [3:0]       y;
    prod_t            p1;
    prod_t            p2;
    prod_t            p3;

    logic             in_ready;
    logic             out_valid;
    logic             out_ovf;
    logic [ACC_W-1:0] out_data;

    logic             in_ready9;
    logic             out_valid9;
    logic             out_ovf9;
    logic [8:0]       out_data9;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Multiplier model: three register stages, never stalls.
    always @(posedge clk) begin
        p1 <= prod_t'(x) * prod_t'(y);
        p2 <= p1;
        p3 <= p2;
    end

    product_accumulator #(
        .LATENCY (MULT_LATENCY),
        .PROD_W  (PROD_W),
        .ACC_W   (ACC_W),
        .COUNT   (COUNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (p3),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    product_accumulator #(
        .LATENCY (MULT_LATENCY),
        .PROD_W  (PROD_W),
        .ACC_W   (9),
        .COUNT   (COUNT)
    ) dut9 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready9),
        .z         (p3),
        .out_data  (out_data9),
        .out_valid (out_valid9),
        .out_ready (out_ready),
        .out_ovf   (out_ovf9)
    );

    // Inputs change 2 time units after the rising edge; outputs are read there
    // or 1 unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_q[$];
        int grp_sum;
        int grp_n;
        int groups_issued;
        int groups_seen;
        int budget;

        // ---------------- reset ----------------
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_out_ovf",   32'(out_ovf),   0);
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_in_ready9", 32'(in_ready9), 1);
        rst = 1'b0;

        // ---------------- 15x15 four times ----------------
        x = 4'd15; y = 4'd15; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("max_no_early", 32'(out_valid), 0);
            tick();
        end
        check("max_valid",  32'(out_valid),  1);
        check("max_data",   32'(out_data),   900);
        check("max_ovf",    32'(out_ovf),    0);
        check("acc9_valid", 32'(out_valid9), 1);
        check("acc9_data",  32'(out_data9),  EXP9);
        check("acc9_ovf",   32'(out_ovf9),   1);
        tick();
        check("max_single_pulse", 32'(out_valid), 0);

        // ---------------- two groups held by out_ready=0 ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = 4'd1; y = 4'(i + 1); in_valid = 1'b1;
            #1;
            check("stall_in_ready", 32'(in_ready), (i == 7) ? 0 : 1);
            if (i < 7) tick();
        end
        check("stall_first_valid", 32'(out_valid), 1);
        check("stall_first_data",  32'(out_data),  10);
        tick();
        #1;
        check("stall_hold_ready", 32'(in_ready),  0);
        check("stall_hold_valid", 32'(out_valid), 1);
        check("stall_hold_data",  32'(out_data),  10);
        tick();
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_gap", 32'(out_valid), 0);
            tick();
        end
        check("stall_second_valid", 32'(out_valid), 1);
        check("stall_second_data",  32'(out_data),  26);
        tick();
        check("stall_second_gone", 32'(out_valid), 0);

        // ---------------- back-to-back groups, out_ready=1 ----------------
        for (int i = 0; i < 8; i++) begin
            x = (i < 4) ? 4'd3 : 4'd2; y = 4'(i + 1); in_valid = 1'b1;
            #1;
            check("b2b_in_ready", 32'(in_ready), 1);
            if (i == 7) begin
                check("b2b_first_valid", 32'(out_valid), 1);
                check("b2b_first_data",  32'(out_data),  30);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("b2b_gap", 32'(out_valid), 0);
            tick();
        end
        check("b2b_second_valid", 32'(out_valid), 1);
        check("b2b_second_data",  32'(out_data),  52);
        tick();
        check("b2b_second_gone", 32'(out_valid), 0);

        // ---------------- reset mid-group ----------------
        x = 4'd9; y = 4'd9; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        tick();
        rst = 1'b0;
        x = 4'd2; y = 4'd3; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_stale", 32'(out_valid), 0);
            tick();
        end
        check("mid_rst_valid_after", 32'(out_valid), 1);
        check("mid_rst_data",        32'(out_data),  24);
        tick();

        // ---------------- random gaps and backpressure ----------------
        grp_sum = 0; grp_n = 0; groups_issued = 0; groups_seen = 0; budget = 0;
        while ((groups_issued < N_RAND || exp_q.size() != 0) && budget < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (groups_issued < N_RAND) && ($urandom_range(0, 3) != 0);
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_result", 32'(out_valid), 0);
                end else begin
                    check("rand_result", 32'(out_data), 32'(exp_q.pop_front()));
                    groups_seen++;
                end
            end
            if (in_valid && in_ready) begin
                grp_sum += int'(x) * int'(y);
                grp_n++;
                if (grp_n == COUNT) begin
                    exp_q.push_back(grp_sum);
                    grp_sum = 0;
                    grp_n   = 0;
                    groups_issued++;
                end
            end
            tick();
            budget++;
        end
        check("rand_groups_seen", 32'(groups_seen), N_RAND);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rand_drained", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
